// File: rtl/lampfpu_div_issue_pkg.sv
// Shared lampFPU definitions used by the divider issue stage: float width and
// the issue FSM state encoding.
package lampfpu_div_issue_pkg;
  localparam int LAMP_FLOAT_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_state_e;
endpackage

// File: rtl/lampfpu_div_issue.sv
// Issue stage between the CPU and a multi-cycle FP divider: captures one request,
// starts the divider, waits for its result and returns it with the request tag.
module lampfpu_div_issue
  import lampfpu_div_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [LAMP_FLOAT_DW-1:0] req_op1_i,
  input  logic [LAMP_FLOAT_DW-1:0] req_op2_i,
  input  logic                     req_rnd_i,
  input  logic [4:0]               req_tag_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [LAMP_FLOAT_DW-1:0] rsp_result_o,
  output logic [4:0]               rsp_tag_o,
  input  logic                     flush_i,
  output logic                     div_start_o,
  output logic [LAMP_FLOAT_DW-1:0] div_op1_o,
  output logic [LAMP_FLOAT_DW-1:0] div_op2_o,
  output logic                     div_rnd_o,
  output logic                     div_adv_o,
  input  logic [LAMP_FLOAT_DW-1:0] div_result_i,
  input  logic                     div_valid_i,
  input  logic                     div_ready_i,
  output logic                     busy_o,
  output logic                     err_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ERR = CW'(TIMEOUT_CYCLES - 1);

  div_state_e               state_q;
  logic [LAMP_FLOAT_DW-1:0] op1_q, op2_q, res_q;
  logic                     rnd_q, kill_q, err_q;
  logic [4:0]               tag_q;
  logic [CW-1:0]            cnt_q;
  logic                     accept;

  // A divider still presenting a result must be drained before a new start.
  assign req_ready_o  = !rst && (state_q == IDLE) && div_ready_i && !div_valid_i && !flush_i;
  assign accept       = req_valid_i && req_ready_o;
  assign div_start_o  = !rst && (state_q == ISSUE);
  assign div_adv_o    = !rst && (state_q == WAIT) && div_valid_i;
  assign rsp_valid_o  = !rst && (state_q == RESP);
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign div_rnd_o    = rnd_q;
  assign rsp_result_o = res_q;
  assign rsp_tag_o    = tag_q;
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      rnd_q   <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op1_q   <= req_op1_i;
            op2_q   <= req_op2_i;
            rnd_q   <= req_rnd_i;
            tag_q   <= req_tag_i;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_i) kill_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (div_valid_i) begin
            // A flush in the same cycle as the result still drains the divider.
            res_q   <= div_result_i;
            kill_q  <= 1'b0;
            state_q <= (kill_q || flush_i) ? IDLE : RESP;
          end else begin
            if (flush_i) kill_q <= 1'b1;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            if (cnt_q >= CNT_ERR) err_q <= 1'b1;
          end
        end
        RESP: begin
          if (flush_i || rsp_ready_i) begin
            kill_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lampfpu_div_issue.sv
// Directed bench for the divider issue stage with a behavioural divider of
// programmable latency; cycle 0 is the request-accept cycle in every scenario.
module tb_lampfpu_div_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_rnd_i;
  logic [15:0] req_op1_i, req_op2_i;
  logic [4:0]  req_tag_i, rsp_tag_o;
  logic        rsp_valid_o, rsp_ready_i, flush_i;
  logic [15:0] rsp_result_o;
  logic        div_start_o, div_rnd_o, div_adv_o;
  logic [15:0] div_op1_o, div_op2_o, div_result_i;
  logic        div_valid_i, div_ready_i, busy_o, err_o;

  int checks = 0;
  int failures = 0;

  lampfpu_div_issue #(.TIMEOUT_CYCLES(63)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_rnd_i(req_rnd_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
    .flush_i(flush_i),
    .div_start_o(div_start_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_rnd_o(div_rnd_o), .div_adv_o(div_adv_o),
    .div_result_i(div_result_i), .div_valid_i(div_valid_i), .div_ready_i(div_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Behavioural divider: result valid dlat cycles after the start cycle, held until adv.
  int          dlat = 10;
  int          dcnt = 0;
  logic        dpend = 1'b0;
  logic [15:0] dres = 16'h0;

  function automatic logic [15:0] fdiv(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h4040 && b == 16'h4000) return 16'h3FC0;  // 3.0 / 2.0 = 1.5
    if (a == 16'h3F80 && b == 16'h4000) return 16'h3F00;  // 1.0 / 2.0 = 0.5
    return 16'h7FC0;
  endfunction

  always @(posedge clk) begin
    if (rst) dpend <= 1'b0;
    else if (div_start_o) begin
      dpend <= 1'b1;
      dcnt  <= dlat - 1;
      dres  <= fdiv(div_op1_o, div_op2_o);
    end else if (dpend && div_adv_o) dpend <= 1'b0;
    else if (dpend && dcnt > 0) dcnt <= dcnt - 1;
  end
  assign div_valid_i  = dpend && (dcnt == 0);
  assign div_result_i = div_valid_i ? dres : 16'h0;
  assign div_ready_i  = !dpend;

  int n_start = 0, n_adv = 0, n_rspv = 0;
  always @(posedge clk) begin
    if (div_start_o) n_start <= n_start + 1;
    if (div_adv_o)   n_adv   <= n_adv + 1;
    if (rsp_valid_o) n_rspv  <= n_rspv + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic [4:0] t);
    req_valid_i = 1'b1; req_op1_i = a; req_op2_i = b; req_tag_i = t; req_rnd_i = 1'b0;
  endtask

  int s0, a0, r0;

  initial begin
    rst = 1'b1; req_valid_i = 0; req_op1_i = 0; req_op2_i = 0; req_rnd_i = 0; req_tag_i = 0;
    rsp_ready_i = 1'b1; flush_i = 1'b0;
    nxt(); nxt(); #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_start", div_start_o, 0);
    chk("rst_adv", div_adv_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_result", 32'(rsp_result_o), 0);
    chk("rst_tag", 32'(rsp_tag_o), 0);
    chk("rst_div_op1", 32'(div_op1_o), 0);
    nxt(); rst = 1'b0;

    // Basic request: start at cycle 1, response at cycle 12.
    nxt(); s0 = n_start;
    drive_req(16'h4040, 16'h4000, 5'd3); #1;
    chk("t31_ready", req_ready_o, 1);
    nxt(); req_valid_i = 1'b0; #1;
    chk("t31_start", div_start_o, 1);
    chk("t31_op1", 32'(div_op1_o), 32'h4040);
    chk("t31_op2", 32'(div_op2_o), 32'h4000);
    chk("t31_busy", busy_o, 1);
    for (int c = 2; c <= 11; c++) begin
      nxt(); #1;
      chk("t31_no_start", div_start_o, 0);
      chk("t31_no_rsp", rsp_valid_o, 0);
      if (c == 11) chk("t31_adv", div_adv_o, 1);
      else chk("t31_no_adv", div_adv_o, 0);
    end
    nxt(); #1;
    chk("t31_rsp_valid", rsp_valid_o, 1);
    chk("t31_result", 32'(rsp_result_o), 32'h3FC0);
    chk("t31_tag", 32'(rsp_tag_o), 3);
    chk("t31_one_start", 32'(n_start - s0), 1);
    nxt(); #1;
    chk("t31_idle", busy_o, 0);
    chk("t31_rsp_drop", rsp_valid_o, 0);

    // Response back-pressure for 5 cycles.
    nxt(); rsp_ready_i = 1'b0;
    drive_req(16'h4040, 16'h4000, 5'd3); #1;
    chk("t32_ready", req_ready_o, 1);
    nxt(); req_valid_i = 1'b0;
    for (int c = 2; c <= 11; c++) nxt();
    for (int c = 12; c <= 16; c++) begin
      nxt(); req_valid_i = 1'b1; #1;
      chk("t32_rsp_valid", rsp_valid_o, 1);
      chk("t32_result", 32'(rsp_result_o), 32'h3FC0);
      chk("t32_tag", 32'(rsp_tag_o), 3);
      chk("t32_req_ready", req_ready_o, 0);
    end
    nxt(); req_valid_i = 1'b0; rsp_ready_i = 1'b1; #1;
    chk("t32_rsp_valid_hs", rsp_valid_o, 1);
    nxt(); #1;
    chk("t32_idle", busy_o, 0);

    // Flush in WAIT cycle 4 (cycle 5): drain the divider, no response.
    nxt(); a0 = n_adv; r0 = n_rspv;
    drive_req(16'h4040, 16'h4000, 5'd9); #1;
    chk("t33_ready", req_ready_o, 1);
    nxt(); req_valid_i = 1'b0;
    for (int c = 2; c <= 4; c++) nxt();
    nxt(); flush_i = 1'b1; #1;
    chk("t33_busy_flush", busy_o, 1);
    nxt(); flush_i = 1'b0;
    for (int c = 7; c <= 10; c++) nxt();
    nxt(); #1;
    chk("t33_valid", div_valid_i, 1);
    chk("t33_adv", div_adv_o, 1);
    chk("t33_no_rsp", rsp_valid_o, 0);
    nxt(); #1;
    chk("t33_idle", busy_o, 0);
    nxt(); nxt(); #1;
    chk("t33_adv_count", 32'(n_adv - a0), 1);
    chk("t33_rsp_count", 32'(n_rspv - r0), 0);

    // Flush in RESP drops the response.
    drive_req(16'h4040, 16'h4000, 5'd4); #1;
    chk("t22_ready", req_ready_o, 1);
    nxt(); req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    for (int c = 2; c <= 11; c++) nxt();
    nxt(); flush_i = 1'b1; #1;
    chk("t22_rsp_valid", rsp_valid_o, 1);
    nxt(); flush_i = 1'b0; rsp_ready_i = 1'b1; #1;
    chk("t22_rsp_dropped", rsp_valid_o, 0);
    chk("t22_idle", busy_o, 0);

    // Flush in IDLE blocks acceptance.
    nxt(); drive_req(16'h4040, 16'h4000, 5'd5); flush_i = 1'b1; #1;
    chk("t23_ready_blocked", req_ready_o, 0);
    nxt(); req_valid_i = 1'b0; flush_i = 1'b0; #1;
    chk("t23_idle", busy_o, 0);

    // Back-to-back with req_valid held.
    nxt(); s0 = n_start;
    drive_req(16'h4040, 16'h4000, 5'd3); #1;
    chk("t35_ready0", req_ready_o, 1);
    nxt(); drive_req(16'h3F80, 16'h4000, 5'd7); #1;
    chk("t35_ready_issue", req_ready_o, 0);
    for (int c = 2; c <= 10; c++) nxt();
    nxt(); #1;
    chk("t35_ready_divvalid", req_ready_o, 0);
    nxt(); #1;
    chk("t35_rsp1_result", 32'(rsp_result_o), 32'h3FC0);
    chk("t35_rsp1_tag", 32'(rsp_tag_o), 3);
    chk("t35_ready_resp", req_ready_o, 0);
    nxt(); #1;
    chk("t35_ready2", req_ready_o, 1);
    nxt(); req_valid_i = 1'b0; #1;
    chk("t35_start2", div_start_o, 1);
    chk("t35_op1_2", 32'(div_op1_o), 32'h3F80);
    for (int c = 15; c <= 24; c++) nxt();
    nxt(); #1;
    chk("t35_rsp2_valid", rsp_valid_o, 1);
    chk("t35_rsp2_result", 32'(rsp_result_o), 32'h3F00);
    chk("t35_rsp2_tag", 32'(rsp_tag_o), 7);
    chk("t35_two_starts", 32'(n_start - s0), 2);
    nxt(); #1;
    chk("t35_idle", busy_o, 0);

    // Latency 70: sticky timeout after 63 WAIT cycles, result still delivered.
    dlat = 70;
    nxt(); drive_req(16'h4040, 16'h4000, 5'd1); #1;
    chk("t34_ready", req_ready_o, 1);
    for (int c = 1; c <= 71; c++) begin
      nxt(); req_valid_i = 1'b0; #1;
      if (c == 64) chk("t34_err_before", err_o, 0);
      if (c == 65) chk("t34_err_rise", err_o, 1);
      if (c == 71) chk("t34_adv", div_adv_o, 1);
    end
    nxt(); #1;
    chk("t34_rsp_valid", rsp_valid_o, 1);
    chk("t34_result", 32'(rsp_result_o), 32'h3FC0);
    chk("t34_err_held", err_o, 1);
    nxt(); #1;
    chk("t34_idle", busy_o, 0);
    chk("t34_err_sticky", err_o, 1);
    dlat = 10;

    // Reset in WAIT: abandon without adv, then a fresh request works.
    nxt(); a0 = n_adv;
    drive_req(16'h4040, 16'h4000, 5'd3); #1;
    chk("t36_ready", req_ready_o, 1);
    nxt(); req_valid_i = 1'b0;
    for (int c = 2; c <= 4; c++) nxt();
    nxt(); rst = 1'b1;
    nxt(); #1;
    chk("t36_busy", busy_o, 0);
    chk("t36_rsp_valid", rsp_valid_o, 0);
    chk("t36_start", div_start_o, 0);
    chk("t36_adv", div_adv_o, 0);
    chk("t36_req_ready", req_ready_o, 0);
    chk("t36_err", err_o, 0);
    chk("t36_div_op1", 32'(div_op1_o), 0);
    chk("t36_result", 32'(rsp_result_o), 0);
    chk("t36_tag", 32'(rsp_tag_o), 0);
    rst = 1'b0;
    nxt(); drive_req(16'h3F80, 16'h4000, 5'd12); #1;
    chk("t36_ready_after", req_ready_o, 1);
    nxt(); req_valid_i = 1'b0;
    for (int c = 2; c <= 11; c++) nxt();
    nxt(); #1;
    chk("t36_rsp_valid_after", rsp_valid_o, 1);
    chk("t36_result_after", 32'(rsp_result_o), 32'h3F00);
    chk("t36_tag_after", 32'(rsp_tag_o), 12);
    chk("t36_adv_count", 32'(n_adv - a0), 1);
    nxt(); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lampfpu_div_issue.md
LAMPFPU_DIV_ISSUE -- requirements
Module: lampFPU_div_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 63, WAIT cycles before err_o sets.
REQ-002 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid_i in 1, req_ready_o out 1  CPU request handshake.
REQ-005 SHALL have ports req_op1_i, req_op2_i in LAMP_FLOAT_DW  dividend, divisor; req_rnd_i in 1  round mode; req_tag_i in 5  destination tag.
REQ-006 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1  response handshake; rsp_result_o out LAMP_FLOAT_DW; rsp_tag_o out 5.
REQ-007 SHALL have port flush_i  in  1  kill in-flight operation.
REQ-008 SHALL have ports div_start_o out 1, div_op1_o/div_op2_o out LAMP_FLOAT_DW, div_rnd_o out 1, div_adv_o out 1  divider-side drive.
REQ-009 SHALL have ports div_result_i in LAMP_FLOAT_DW, div_valid_i in 1, div_ready_i in 1  divider-side return.
REQ-010 SHALL have ports busy_o out 1 (state != IDLE), err_o out 1 (sticky timeout).

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-012 IDLE: req_ready_o = div_ready_i & !div_valid_i & !flush_i; all other outputs 0 except held data.
REQ-013 On req_valid_i & req_ready_o: capture op1, op2, rnd, tag into registers; next state ISSUE.
REQ-014 div_op1_o/div_op2_o/div_rnd_o SHALL be driven from capture registers, stable from ISSUE until WAIT exit.
REQ-015 ISSUE: div_start_o = 1 for exactly one cycle; next state WAIT.
REQ-016 WAIT: cycle counter increments, saturating at TIMEOUT_CYCLES; reaching it sets err_o (sticky); state remains WAIT.
REQ-017 WAIT with div_valid_i = 1: capture div_result_i, pulse div_adv_o one cycle; next state RESP, or IDLE if kill flag set.
REQ-018 div_adv_o SHALL never assert outside the WAIT-exit cycle; div_start_o never outside ISSUE.
REQ-019 RESP: rsp_valid_o = 1, rsp_result_o/rsp_tag_o stable until rsp_ready_i; on handshake next state IDLE.
REQ-020 Minimum latency: accept at cycle 0, start at cycle 1, rsp_valid_o at cycle D+2 for divider latency D (valid seen D cycles after start).
REQ-021 flush_i in ISSUE or WAIT SHALL set kill flag; start still issued if in ISSUE; divider drained (adv on valid), no response produced.
REQ-022 flush_i in RESP SHALL drop response: rsp_valid_o low next cycle, state IDLE.
REQ-023 flush_i in IDLE SHALL block acceptance that cycle; no other effect.
REQ-024 flush_i and div_valid_i in same WAIT cycle SHALL drain: adv pulsed, no response.
REQ-025 Kill flag and counter SHALL clear on entry to IDLE and ISSUE respectively.

Reset
REQ-026 rst SHALL force state IDLE; req_ready_o, rsp_valid_o, div_start_o, div_adv_o, busy_o, err_o = 0.
REQ-027 rst SHALL clear capture, result and tag registers to 0; rsp/div data outputs read 0.
REQ-028 rst mid-operation SHALL abandon operation without div_adv_o; divider reset shares rst.

Structure
REQ-029 State typedef and LAMP_FLOAT_DW SHALL come from the shared lampFPU package header; TIMEOUT_CYCLES stays local.
REQ-030 Single flat module, no sub-modules; counter width $clog2(TIMEOUT_CYCLES+1).

Verification (LAMP_FLOAT_DW=16, bfloat16; behavioural divider, latency D=10)
REQ-031 req op1=0x4040, op2=0x4000, tag=3 -> one div_start_o at cycle 1, rsp_valid_o at cycle 12 with 0x3FC0, tag 3.
REQ-032 Same request, rsp_ready_i held low 5 cycles -> result/tag stable, req_ready_o 0 throughout, IDLE after handshake.
REQ-033 flush_i in cycle 4 of WAIT -> div_adv_o pulsed when div_valid_i rises, rsp_valid_o never asserts, busy_o falls next cycle.
REQ-034 Divider latency 70 -> err_o rises at WAIT cycle 63, stays 1; result delivered normally at end.
REQ-035 Back-to-back requests with req_valid_i held -> second accepted only after div_valid_i low, two starts, two responses in order.
REQ-036 rst asserted in WAIT -> all outputs 0 next cycle, no div_adv_o, new request accepted after release.
